dmem_access_ctrl: RTL

- Initiator-side controller for the word-wide data memory: the requesting end of the memory's mem_read/mem_write/address/write_data/read_data interface.
- Takes byte-addressed load/store requests from the CPU's MEM stage over a valid/ready handshake and converts them to word accesses.
- Sub-word stores use read-modify-write.
- Checks alignment and address range, then returns sign- or zero-extended load data with a one-cycle response pulse.

---
 rtl/dmem_access_ctrl_pkg.sv | 34 +++
 rtl/dmem_access_ctrl_lane_mux_ext.sv | 41 ++++
 rtl/dmem_access_ctrl.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/dmem_access_ctrl_pkg.sv
// Shared definitions for the data-memory access controller: size codes,
// FSM state encodings, default geometry and a small alignment helper.
package dmem_access_ctrl_pkg;

  localparam int DMEM_DW       = 32;
  localparam int MEM_WORDS_DEF = 32;
  localparam int MEM_LAT_DEF   = 1;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_RD     = 3'd1;
  localparam state_t ST_WR     = 3'd2;
  localparam state_t ST_RMW_RD = 3'd3;
  localparam state_t ST_RMW_WR = 3'd4;
  localparam state_t ST_RESP   = 3'd5;

  // True when the size code is illegal or the low address bits do not
  // match the natural alignment of the access.
  function automatic logic size_align_err(input logic [1:0] size,
                                          input logic [1:0] addr_lo);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return addr_lo[0];
      SZ_WORD: return (addr_lo != 2'b00);
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/dmem_access_ctrl_lane_mux_ext.sv
// Little-endian lane handling: merges store data into a read word and
// extracts a load lane with sign or zero extension.
module lane_mux_ext
  import dmem_access_ctrl_pkg::*;
#(
  parameter int DW = DMEM_DW
) (
  input  logic [DW-1:0] word,
  input  logic [1:0]    addr_lo,
  input  logic [1:0]    size,
  input  logic          sign_ext,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] merged,
  output logic [DW-1:0] extracted
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Replace the addressed lane of the old word with right-aligned store data
  always_comb begin
    merged = word;
    case (size)
      SZ_BYTE: merged[{addr_lo, 3'b000} +: 8]        = wdata[7:0];
      SZ_HALF: merged[{addr_lo[1], 4'b0000} +: 16]   = wdata[15:0];
      default: merged = wdata;
    endcase
  end

  // Pull the addressed lane out of the word and widen it to full width
  always_comb begin
    byte_lane = word[{addr_lo, 3'b000} +: 8];
    half_lane = word[{addr_lo[1], 4'b0000} +: 16];
    case (size)
      SZ_BYTE: extracted = {{(DW-8){sign_ext & byte_lane[7]}}, byte_lane};
      SZ_HALF: extracted = {{(DW-16){sign_ext & half_lane[15]}}, half_lane};
      default: extracted = word;
    endcase
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Initiator-side controller for the word-wide data memory. Accepts byte
// addressed loads/stores, performs read-modify-write for sub-word stores
// and returns a one-cycle response with extended load data or an error.
module dmem_access_ctrl
  import dmem_access_ctrl_pkg::*;
#(
  parameter int DW        = DMEM_DW,
  parameter int MEM_WORDS = MEM_WORDS_DEF,
  parameter int MEM_LAT   = MEM_LAT_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic [1:0]    req_size,
  input  logic          req_signed,
  input  logic [DW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err,
  output logic [DW-1:0] mem_address,
  output logic          mem_read,
  output logic          mem_write,
  output logic [DW-1:0] mem_write_data,
  input  logic [DW-1:0] mem_read_data
);

  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  state_t        state;
  logic [CW-1:0] lat_cnt;
  logic          write_q;
  logic          signed_q;
  logic          err_q;
  logic [1:0]    size_q;
  logic [DW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] rdata_q;

  logic [DW-1:0] req_word_idx;
  logic [DW-1:0] word_idx_q;
  logic          req_err;
  logic          accept;
  logic [DW-1:0] merged;
  logic [DW-1:0] extracted;

  assign req_word_idx = {2'b00, req_addr[DW-1:2]};
  assign word_idx_q   = {2'b00, addr_q[DW-1:2]};
  assign req_err      = size_align_err(req_size, req_addr[1:0]) ||
                        (req_word_idx >= DW'(MEM_WORDS));
  assign accept       = req_valid && (state == ST_IDLE);

  lane_mux_ext #(.DW(DW)) u_lane (
    .word      (rdata_q),
    .addr_lo   (addr_q[1:0]),
    .size      (size_q),
    .sign_ext  (signed_q),
    .wdata     (wdata_q),
    .merged    (merged),
    .extracted (extracted)
  );

  // Sequence each accepted request through read, write or RMW and then respond
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      lat_cnt  <= '0;
      write_q  <= 1'b0;
      signed_q <= 1'b0;
      err_q    <= 1'b0;
      size_q   <= 2'b00;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            write_q  <= req_write;
            signed_q <= req_signed;
            err_q    <= req_err;
            size_q   <= req_size;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            lat_cnt  <= CW'(MEM_LAT - 1);
            if (req_err)                  state <= ST_RESP;
            else if (!req_write)          state <= ST_RD;
            else if (req_size == SZ_WORD) state <= ST_WR;
            else                          state <= ST_RMW_RD;
          end
        end
        ST_RD, ST_RMW_RD: begin
          if (lat_cnt == '0) begin
            rdata_q <= mem_read_data;
            state   <= (state == ST_RD) ? ST_RESP : ST_RMW_WR;
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        ST_WR, ST_RMW_WR: state <= ST_RESP;
        ST_RESP:          state <= ST_IDLE;
        default:          state <= ST_IDLE;
      endcase
    end
  end

  // Decode memory strobes and the response from the current state
  always_comb begin
    req_ready      = (state == ST_IDLE);
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_address    = '0;
    mem_write_data = '0;
    rsp_valid      = 1'b0;
    rsp_err        = 1'b0;
    rsp_rdata      = '0;
    case (state)
      ST_RD, ST_RMW_RD: begin
        mem_read    = 1'b1;
        mem_address = word_idx_q;
      end
      ST_WR: begin
        mem_write      = 1'b1;
        mem_address    = word_idx_q;
        mem_write_data = wdata_q;
      end
      ST_RMW_WR: begin
        mem_write      = 1'b1;
        mem_address    = word_idx_q;
        mem_write_data = merged;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        rsp_err   = err_q;
        if (!err_q && !write_q) rsp_rdata = extracted;
      end
      default: ;
    endcase
  end

endmodule
